// File: rtl/pipe_stage_fifo_pkg.sv
// Shared stage-bus widths for the inter-stage buffer and its users.
// The instantiating stage packs/unpacks fields; this block only sees the flat word.
package pipe_stage_fifo_pkg;

  localparam int REG_W       = 32;
  localparam int NUM_REGS    = 9;
  localparam int CTRL_W      = 12;
  localparam int RD_ADDR_W   = 5;
  localparam int FUNCT_W     = 3;
  localparam int KIND_W      = 2;

  localparam int STAGE_BUS_W = REG_W * NUM_REGS + CTRL_W + RD_ADDR_W + FUNCT_W + KIND_W;

endpackage

// File: rtl/pipe_stage_fifo_if.sv
// Valid/ready/data stream between two pipeline stages.
// master drives valid/data, slave drives ready.
interface pipe_stage_fifo_if
  import pipe_stage_fifo_pkg::*;
#(
  parameter int WIDTH = STAGE_BUS_W
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_fifo_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one async read port.
// Storage is deliberately not reset.
module pipe_fifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_stage_fifo.sv
// Inter-stage pipeline buffer with occupancy count and synchronous flush.
// Define CONFIG_PIPE_BYPASS_EN for a combinational s->m path while empty.
module pipe_stage_fifo
  import pipe_stage_fifo_pkg::*;
#(
  parameter int WIDTH = STAGE_BUS_W,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  pipe_stage_fifo_if.slave  s_bus,
  pipe_stage_fifo_if.master m_bus,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] rdata;
  logic             empty, full, byp, push, pop, store, deq;

  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));

`ifdef CONFIG_PIPE_BYPASS_EN
  assign byp = empty & ~flush;
`else
  assign byp = 1'b0;
`endif

  // ready looks only at registered occupancy, never at m_bus.ready
  assign s_bus.ready = ~full;
  assign m_bus.valid = ~empty | (byp & s_bus.valid);
  assign m_bus.data  = ~empty ? rdata : (byp ? s_bus.data : '0);

  assign push  = s_bus.valid & s_bus.ready;
  assign pop   = m_bus.valid & m_bus.ready;
  // a bypassed word that is consumed in the same cycle is never stored
  assign store = push & ~(byp & m_bus.ready);
  assign deq   = pop & ~empty;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    cnt_nxt    = cnt;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      cnt_nxt    = '0;
    end else begin
      if (store) wr_ptr_nxt = wr_ptr + PTR_W'(1);
      if (deq)   rd_ptr_nxt = rd_ptr + PTR_W'(1);
      cnt_nxt = cnt + CNT_W'(store) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      cnt    <= cnt_nxt;
    end
  end

  pipe_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (store & ~flush),
    .waddr (wr_ptr),
    .wdata (s_bus.data),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign count = cnt;

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Directed bench for pipe_stage_fifo (DEPTH=2, default WIDTH).
// Exercises reset, streaming, backpressure, full-with-pop, flush and async reset.
module tb_pipe_stage_fifo;
  import pipe_stage_fifo_pkg::*;

  localparam int W = STAGE_BUS_W;
  localparam int D = 2;
  localparam int CW = $clog2(D) + 1;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [CW-1:0] count;
  int            checks;
  int            failures;

  pipe_stage_fifo_if #(.WIDTH(W)) s_bus ();
  pipe_stage_fifo_if #(.WIDTH(W)) m_bus ();

  pipe_stage_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .s_bus (s_bus),
    .m_bus (m_bus),
    .count (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    s_bus.valid = 1'b0; s_bus.data = '0; m_bus.ready = 1'b0;
    #2;
    checks++; if (count !== 0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (m_bus.valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid got=%0b exp=0", m_bus.valid); end
    checks++; if (m_bus.data !== W'(0)) begin failures++; $display("FAIL rst_m_data got=%0h exp=0", m_bus.data); end
    checks++; if (s_bus.ready !== 1'b1) begin failures++; $display("FAIL rst_s_ready got=%0b exp=1", s_bus.ready); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_streaming();
    m_bus.ready = 1'b1;
    s_bus.valid = 1'b1; s_bus.data = W'(32'h1);
    #1;
    checks++; if (m_bus.valid !== 1'b0) begin failures++; $display("FAIL stream_no_bypass got=%0b exp=0", m_bus.valid); end
    step();
    checks++; if (count !== 1 || m_bus.data !== W'(32'h1)) begin failures++; $display("FAIL stream_w1 got cnt=%0d data=%0h exp cnt=1 data=1", count, m_bus.data); end
    s_bus.data = W'(32'h2);
    step();
    checks++; if (count !== 1 || m_bus.data !== W'(32'h2)) begin failures++; $display("FAIL stream_w2 got cnt=%0d data=%0h exp cnt=1 data=2", count, m_bus.data); end
    s_bus.data = W'(32'h3);
    step();
    checks++; if (count !== 1 || m_bus.data !== W'(32'h3) || m_bus.valid !== 1'b1) begin failures++; $display("FAIL stream_w3 got cnt=%0d data=%0h vld=%0b exp cnt=1 data=3 vld=1", count, m_bus.data, m_bus.valid); end
    s_bus.valid = 1'b0;
    step();
    checks++; if (count !== 0 || m_bus.valid !== 1'b0 || m_bus.data !== W'(0)) begin failures++; $display("FAIL stream_drain got cnt=%0d vld=%0b data=%0h exp cnt=0 vld=0 data=0", count, m_bus.valid, m_bus.data); end
  endtask

  task automatic test_bypass();
    m_bus.ready = 1'b1;
    s_bus.valid = 1'b1; s_bus.data = W'(32'h55);
    #1;
    checks++; if (m_bus.valid !== 1'b1 || m_bus.data !== W'(32'h55)) begin failures++; $display("FAIL bypass_same_cycle got vld=%0b data=%0h exp vld=1 data=55", m_bus.valid, m_bus.data); end
    checks++; if (s_bus.ready !== 1'b1) begin failures++; $display("FAIL bypass_s_ready got=%0b exp=1", s_bus.ready); end
    step();
    s_bus.valid = 1'b0;
    #1;
    checks++; if (count !== 0 || m_bus.valid !== 1'b0) begin failures++; $display("FAIL bypass_count got cnt=%0d vld=%0b exp cnt=0 vld=0", count, m_bus.valid); end
  endtask

  task automatic test_backpressure();
    m_bus.ready = 1'b0;
    s_bus.valid = 1'b1; s_bus.data = W'(32'hA);
    step();
    checks++; if (count !== 1 || s_bus.ready !== 1'b1) begin failures++; $display("FAIL bp_one got cnt=%0d rdy=%0b exp cnt=1 rdy=1", count, s_bus.ready); end
    s_bus.data = W'(32'hB);
    step();
    checks++; if (count !== 2 || s_bus.ready !== 1'b0) begin failures++; $display("FAIL bp_full got cnt=%0d rdy=%0b exp cnt=2 rdy=0", count, s_bus.ready); end
    s_bus.data = W'(32'hC);
    step();
    checks++; if (count !== 2 || m_bus.data !== W'(32'hA)) begin failures++; $display("FAIL bp_hold got cnt=%0d data=%0h exp cnt=2 data=a", count, m_bus.data); end
    m_bus.ready = 1'b1;
    step();
    checks++; if (count !== 1 || m_bus.data !== W'(32'hB) || s_bus.ready !== 1'b1) begin failures++; $display("FAIL bp_pop_a got cnt=%0d data=%0h rdy=%0b exp cnt=1 data=b rdy=1", count, m_bus.data, s_bus.ready); end
    step();
    checks++; if (count !== 1 || m_bus.data !== W'(32'hC)) begin failures++; $display("FAIL bp_pop_b got cnt=%0d data=%0h exp cnt=1 data=c", count, m_bus.data); end
    s_bus.valid = 1'b0;
    step();
    checks++; if (count !== 0 || m_bus.valid !== 1'b0) begin failures++; $display("FAIL bp_drain got cnt=%0d vld=%0b exp cnt=0 vld=0", count, m_bus.valid); end
  endtask

  task automatic test_full_pop();
    m_bus.ready = 1'b0;
    s_bus.valid = 1'b1; s_bus.data = W'(32'hD);
    step();
    s_bus.data = W'(32'hE);
    step();
    s_bus.data = W'(32'hF);
    m_bus.ready = 1'b1;
    #1;
    checks++; if (s_bus.ready !== 1'b0 || m_bus.data !== W'(32'hD)) begin failures++; $display("FAIL fullpop_pre got rdy=%0b data=%0h exp rdy=0 data=d", s_bus.ready, m_bus.data); end
    step();
    s_bus.valid = 1'b0;
    m_bus.ready = 1'b0;
    #1;
    checks++; if (count !== 1 || s_bus.ready !== 1'b1 || m_bus.data !== W'(32'hE)) begin failures++; $display("FAIL fullpop_post got cnt=%0d rdy=%0b data=%0h exp cnt=1 rdy=1 data=e", count, s_bus.ready, m_bus.data); end
    m_bus.ready = 1'b1;
    step();
    m_bus.ready = 1'b0;
    checks++; if (count !== 0) begin failures++; $display("FAIL fullpop_drain got cnt=%0d exp=0", count); end
  endtask

  task automatic test_flush();
    m_bus.ready = 1'b0;
    s_bus.valid = 1'b1; s_bus.data = W'(32'h11);
    step();
    s_bus.data = W'(32'h22);
    step();
    s_bus.data = W'(32'h33);
    m_bus.ready = 1'b1;
    flush = 1'b1;
    #1;
    checks++; if (m_bus.valid !== 1'b1 || m_bus.data !== W'(32'h11) || count !== 2) begin failures++; $display("FAIL flush_pre got vld=%0b data=%0h cnt=%0d exp vld=1 data=11 cnt=2", m_bus.valid, m_bus.data, count); end
    step();
    flush = 1'b0; s_bus.valid = 1'b0; m_bus.ready = 1'b0;
    #1;
    checks++; if (count !== 0 || m_bus.valid !== 1'b0 || m_bus.data !== W'(0)) begin failures++; $display("FAIL flush_full got cnt=%0d vld=%0b data=%0h exp cnt=0 vld=0 data=0", count, m_bus.valid, m_bus.data); end
    // one entry held, flush discards a push that would otherwise be accepted
    s_bus.valid = 1'b1; s_bus.data = W'(32'h44);
    step();
    s_bus.data = W'(32'h55);
    flush = 1'b1;
    step();
    flush = 1'b0; s_bus.valid = 1'b0;
    step();
    checks++; if (count !== 0 || m_bus.valid !== 1'b0) begin failures++; $display("FAIL flush_push got cnt=%0d vld=%0b exp cnt=0 vld=0", count, m_bus.valid); end
    s_bus.valid = 1'b1; s_bus.data = W'(32'h66);
    step();
    s_bus.valid = 1'b0;
    checks++; if (count !== 1 || m_bus.data !== W'(32'h66)) begin failures++; $display("FAIL flush_after got cnt=%0d data=%0h exp cnt=1 data=66", count, m_bus.data); end
    m_bus.ready = 1'b1;
    step();
    m_bus.ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    m_bus.ready = 1'b0;
    s_bus.valid = 1'b1; s_bus.data = W'(32'h77);
    step();
    s_bus.data = W'(32'h88);
    step();
    s_bus.valid = 1'b0;
    checks++; if (count !== 2) begin failures++; $display("FAIL rstmid_fill got cnt=%0d exp=2", count); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 0 || m_bus.valid !== 1'b0 || m_bus.data !== W'(0) || s_bus.ready !== 1'b1) begin failures++; $display("FAIL rstmid_async got cnt=%0d vld=%0b data=%0h rdy=%0b exp cnt=0 vld=0 data=0 rdy=1", count, m_bus.valid, m_bus.data, s_bus.ready); end
    #1;
    rst_n = 1'b1;
    step();
    checks++; if (count !== 0 || m_bus.valid !== 1'b0) begin failures++; $display("FAIL rstmid_after got cnt=%0d vld=%0b exp cnt=0 vld=0", count, m_bus.valid); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
`ifdef CONFIG_PIPE_BYPASS_EN
    test_bypass();
`else
    test_streaming();
`endif
    test_backpressure();
    test_full_pop();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
